// File: rtl/vga_disp_pkg.sv
// vga_disp_pkg: shared frame-buffer FSM state type and default geometry constants
package vga_disp_pkg;
  localparam int FB_ADDR_W = 9;
  localparam int FB_MAG_W  = 24;
  localparam int FB_H_W    = 9;
  localparam int FB_H_MAX  = 479;
  typedef enum logic {ST_FILL = 1'b0, ST_COMPLETE = 1'b1} fb_state_e;
endpackage

// File: rtl/mag_to_height.sv
// mag_to_height: combinational magnitude-to-bar-height conversion (linear shift or 8*msb+3 fraction bits), saturated to H_MAX
//   mag_i      in  MAG_W  bin magnitude
//   log_mode_i in  1      1 = log scale, 0 = linear
//   height_o   out H_W    bar height
module mag_to_height #(
  parameter int MAG_W     = 24,
  parameter int H_W       = 9,
  parameter int H_MAX     = 479,
  parameter int LIN_SHIFT = 12
) (
  input  logic [MAG_W-1:0] mag_i,
  input  logic             log_mode_i,
  output logic [H_W-1:0]   height_o
);
  localparam int PW = $clog2(MAG_W);
  logic [PW-1:0]    msb;
  logic [MAG_W-1:0] lin, norm;
  logic [PW+2:0]    lg;
  always_comb begin
    msb = '0;
    for (int i = 0; i < MAG_W; i++) if (mag_i[i]) msb = PW'(i);
    // left-align the msb so the three bits below it sit at the top of the word
    norm = mag_i << (PW'(MAG_W - 1) - msb);
    lin = mag_i >> LIN_SHIFT;
    lg = {msb, 3'(norm >> (MAG_W - 4))};
    height_o = log_mode_i ? ((mag_i == '0) ? '0 : (32'(lg) > H_MAX) ? H_W'(H_MAX) : H_W'(lg))
                          : ((32'(lin) > H_MAX) ? H_W'(H_MAX) : H_W'(lin));
  end
endmodule

// File: rtl/spectrum_frame_buffer.sv
// spectrum_frame_buffer: double-buffered spectrum bar-height store with vblank swap, drop counter and optional peak hold (PEAK_HOLD_EN)
//   clk, reset_n            clock, async active-low reset
//   i_bin_valid/addr/mag    incoming bin strobe, index, magnitude
//   i_log_mode              1 = log scale, 0 = linear (applies to bins written from then on)
//   i_swap_req              vblank pulse; swaps banks only once a frame is complete
//   i_rd_addr               display read address
//   o_rd_height, o_rd_peak  front-buffer height and peak-hold height, 1-cycle latency, 0 until a frame exists
//   o_frame_valid           high once a front buffer exists
//   o_swap_ack              single-cycle pulse after a swap
//   o_drop_cnt              saturating count of bins dropped while waiting for a swap
module spectrum_frame_buffer
  import vga_disp_pkg::*;
#(
  parameter int ADDR_W    = FB_ADDR_W,
  parameter int MAG_W     = FB_MAG_W,
  parameter int H_W       = FB_H_W,
  parameter int H_MAX     = FB_H_MAX,
  parameter int LIN_SHIFT = 12,
  parameter int DECAY     = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_bin_valid,
  input  logic [ADDR_W-1:0] i_bin_addr,
  input  logic [MAG_W-1:0]  i_bin_mag,
  input  logic              i_log_mode,
  input  logic              i_swap_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [H_W-1:0]    o_rd_height,
  output logic [H_W-1:0]    o_rd_peak,
  output logic              o_frame_valid,
  output logic              o_swap_ack,
  output logic [15:0]       o_drop_cnt
);
  localparam int NUM_BINS = 2 ** ADDR_W;
  fb_state_e      state_q, state_d;
  logic           bank_q, bank_d, valid_q, valid_d, ack_q, ack_d;
  logic [15:0]    drop_q, drop_d;
  logic [H_W-1:0] h, rd_q;
  logic [H_W-1:0] mem_q [2*NUM_BINS];
  logic           accept, swap;
  mag_to_height #(.MAG_W(MAG_W), .H_W(H_W), .H_MAX(H_MAX), .LIN_SHIFT(LIN_SHIFT)) u_m2h (
    .mag_i(i_bin_mag), .log_mode_i(i_log_mode), .height_o(h)
  );
  assign accept = i_bin_valid && state_q == ST_FILL;
  assign swap   = i_swap_req && state_q == ST_COMPLETE;
  always_comb begin
    state_d = swap ? ST_FILL : (accept && &i_bin_addr) ? ST_COMPLETE : state_q;
    bank_d  = bank_q ^ swap;
    valid_d = valid_q | swap;
    ack_d   = swap;
    drop_d  = (i_bin_valid && state_q == ST_COMPLETE && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FILL;
      bank_q  <= 1'b0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      drop_q  <= drop_d;
    end
  end
  // bank_q selects the front half; writes always land in the other half
  always_ff @(posedge clk) begin
    if (accept) mem_q[{~bank_q, i_bin_addr}] <= h;
    rd_q <= mem_q[{bank_q, i_rd_addr}];
  end
  assign o_rd_height   = valid_q ? rd_q : '0;
  assign o_frame_valid = valid_q;
  assign o_swap_ack    = ack_q;
  assign o_drop_cnt    = drop_q;
`ifdef PEAK_HOLD_EN
  logic [H_W-1:0]    peak_q [NUM_BINS];
  logic              pk_v_q, wr_v_q;
  logic [ADDR_W-1:0] pk_addr_q, wr_addr_q;
  logic [H_W-1:0]    pk_h_q, pk_old_q, wr_val_q, pk_rd_q, old, dec, nxt;
  always_comb begin
    // the write committed on the edge that sampled pk_old_q is not visible in it yet
    old = (wr_v_q && wr_addr_q == pk_addr_q) ? wr_val_q : pk_old_q;
    dec = (32'(old) > DECAY) ? old - H_W'(DECAY) : '0;
    nxt = (pk_h_q > dec) ? pk_h_q : dec;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pk_v_q <= 1'b0;
      wr_v_q <= 1'b0;
    end else begin
      pk_v_q <= accept;
      wr_v_q <= pk_v_q;
    end
  end
  always_ff @(posedge clk) begin
    pk_addr_q <= i_bin_addr;
    pk_h_q    <= h;
    pk_old_q  <= peak_q[i_bin_addr];
    wr_addr_q <= pk_addr_q;
    wr_val_q  <= nxt;
    if (pk_v_q) peak_q[pk_addr_q] <= nxt;
    pk_rd_q <= peak_q[i_rd_addr];
  end
  assign o_rd_peak = valid_q ? pk_rd_q : '0;
`else
  assign o_rd_peak = '0;
`endif
endmodule

// File: tb/tb_spectrum_frame_buffer.sv
// tb_spectrum_frame_buffer: scoreboard bench for spectrum_frame_buffer (peak checks active when PEAK_HOLD_EN is defined)
module tb_spectrum_frame_buffer;
`ifdef PEAK_HOLD_EN
  localparam bit PK_EN = 1'b1;
`else
  localparam bit PK_EN = 1'b0;
`endif
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        i_bin_valid = 1'b0, i_log_mode = 1'b0, i_swap_req = 1'b0;
  logic [8:0]  i_bin_addr = '0, i_rd_addr = '0;
  logic [23:0] i_bin_mag = '0;
  logic [8:0]  o_rd_height, o_rd_peak;
  logic        o_frame_valid, o_swap_ack;
  logic [15:0] o_drop_cnt;
  int n_chk = 0, n_pass = 0;
  typedef struct {string tag; int h; int p;} rd_t;
  rd_t sb[$];
  int  mem[2][512];
  int  pk[512];
  bit  m_bank = 0, m_fill = 1, m_valid = 0;
  int  m_drop = 0;
  spectrum_frame_buffer dut (
    .clk(clk), .reset_n(reset_n), .i_bin_valid(i_bin_valid), .i_bin_addr(i_bin_addr),
    .i_bin_mag(i_bin_mag), .i_log_mode(i_log_mode), .i_swap_req(i_swap_req), .i_rd_addr(i_rd_addr),
    .o_rd_height(o_rd_height), .o_rd_peak(o_rd_peak), .o_frame_valid(o_frame_valid),
    .o_swap_ack(o_swap_ack), .o_drop_cnt(o_drop_cnt)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask
  function automatic int m2h(input int unsigned m, input bit lg);
    int p, f, v;
    if (!lg) begin
      v = int'(m >> 12);
      return v > 479 ? 479 : v;
    end
    if (m == 0) return 0;
    p = 0;
    while ((m >> p) > 1) p++;
    f = (p >= 3) ? int'((m >> (p - 3)) & 7) : int'((m << (3 - p)) & 7);
    v = 8 * p + f;
    return v > 479 ? 479 : v;
  endfunction
  function automatic int unsigned rnd_mag();
    return $urandom_range(0, 24'hFFFFFF) >> $urandom_range(0, 16);
  endfunction
  task automatic bin_model(input int a, input int unsigned m);
    int h, d;
    if (m_fill) begin
      h = m2h(m, i_log_mode);
      mem[!m_bank][a] = h;
      d = pk[a] > 2 ? pk[a] - 2 : 0;
      pk[a] = h > d ? h : d;
      if (a == 511) m_fill = 0;
    end else if (m_drop < 16'hFFFF) m_drop++;
  endtask
  task automatic send_bin(input int a, input int unsigned m);
    i_bin_valid = 1'b1;
    i_bin_addr = a[8:0];
    i_bin_mag = m[23:0];
    @(posedge clk); #1;
    i_bin_valid = 1'b0;
    bin_model(a, m);
  endtask
  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_bin(i, rnd_mag());
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic swap(input string tag, input bit with_bin);
    bit fire;
    fire = !m_fill;
    i_swap_req = 1'b1;
    if (with_bin) begin
      i_bin_valid = 1'b1;
      i_bin_addr = 9'd0;
      i_bin_mag = 24'd5;
    end
    @(posedge clk); #1;
    i_swap_req = 1'b0;
    i_bin_valid = 1'b0;
    if (with_bin) bin_model(0, 5);
    if (fire) begin
      m_bank = !m_bank;
      m_fill = 1;
      m_valid = 1;
    end
    check({tag, "_ack"}, o_swap_ack, fire);
    check({tag, "_fv"}, o_frame_valid, m_valid);
    tick(1);
    check({tag, "_ack_off"}, o_swap_ack, 0);
  endtask
  task automatic rd(input int a, input string tag, input int xh, input int xp);
    rd_t e;
    e.tag = tag;
    e.h = xh >= 0 ? xh : (m_valid ? mem[m_bank][a] : 0);
    e.p = xp >= 0 ? xp : ((m_valid && PK_EN) ? pk[a] : 0);
    i_rd_addr = a[8:0];
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    check({e.tag, "_h"}, o_rd_height, e.h);
    check({e.tag, "_p"}, o_rd_peak, e.p);
  endtask
  task automatic rd_rand(input string tag, input int n);
    for (int i = 0; i < n; i++) rd($urandom_range(0, 511), tag, -1, -1);
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    m_fill = 1;
    m_bank = 0;
    m_valid = 0;
    m_drop = 0;
    check("rst_fv", o_frame_valid, 0);
    check("rst_ack", o_swap_ack, 0);
    check("rst_drop", o_drop_cnt, 0);
    check("rst_h", o_rd_height, 0);
    check("rst_p", o_rd_peak, 0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask
  initial begin
    for (int i = 0; i < 512; i++) pk[i] = 0;
    tick(3);
    do_reset();
    rd(0, "rst_rd0", 0, 0);
    // frame 1: linear
    i_log_mode = 1'b0;
    send_range(0, 4);
    send_bin(5, 200 << 12);
    send_range(6, 9);
    send_bin(10, 24'hFFFFFF);
    send_bin(11, 0);
    send_range(12, 99);
    swap("mid1", 0);
    rd(0, "mid1_rd", 0, 0);
    send_range(100, 255);
    send_bin(256, 123456);
    send_range(257, 511);
    send_bin(3, rnd_mag());
    send_bin(400, rnd_mag());
    tick(1);
    check("drop2", o_drop_cnt, m_drop);
    check("drop2_const", o_drop_cnt, 2);
    swap("swap1", 0);
    rd(256, "lin256", 30, -1);
    rd(10, "linsat", 479, -1);
    rd(11, "lin0", 0, -1);
    rd(5, "pk1", 200, PK_EN ? 200 : 0);
    rd_rand("f1", 6);
    // frame 2: log mode, out-of-order and repeated writes, mode change mid-frame
    i_log_mode = 1'b1;
    send_range(0, 4);
    send_bin(5, 80);
    send_bin(6, rnd_mag());
    send_bin(7, 500000);
    send_bin(8, 1 << 23);
    send_bin(9, 0);
    send_range(10, 99);
    swap("mid2", 0);
    rd(256, "front_kept", 30, -1);
    send_bin(30, 6144);
    send_bin(30, 32);
    send_bin(30, 3);
    send_bin(40, 1000);
    send_range(100, 199);
    i_log_mode = 1'b0;
    send_range(200, 299);
    i_log_mode = 1'b1;
    send_bin(40, 1 << 20);
    send_range(300, 511);
    swap("swap2", 1);
    check("drop3", o_drop_cnt, m_drop);
    rd(7, "log500k", 151, -1);
    rd(8, "log2p23", 184, -1);
    rd(9, "log0", 0, -1);
    rd(5, "pk2", 50, PK_EN ? 198 : 0);
    rd(30, "fwd30", 12, -1);
    rd(40, "lastwin", 160, -1);
    rd(250, "modechg", -1, -1);
    rd_rand("f2", 6);
    // reset mid-fill, then a full frame
    i_log_mode = 1'b0;
    send_range(0, 300);
    tick(2);
    do_reset();
    rd(256, "rst2_rd", 0, 0);
    swap("after_rst", 0);
    send_range(0, 511);
    swap("swap3", 0);
    check("drop_after_rst", o_drop_cnt, 0);
    rd_rand("f3", 8);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/spectrum_frame_buffer.md
SPECTRUM_FRAME_BUFFER -- requirements
Module: spectrum_frame_buffer

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning bin address width; NUM_BINS = 2**ADDR_W.
REQ-002 SHALL have parameter MAG_W, default 24, meaning input magnitude width.
REQ-003 SHALL have parameter H_W, default 9, meaning bar-height width.
REQ-004 SHALL have parameter H_MAX, default 479, meaning maximum bar height.
REQ-005 SHALL have parameter LIN_SHIFT, default 12, meaning right shift applied in linear mode.
REQ-006 SHALL have parameter DECAY, default 2, meaning peak decay per frame update.
REQ-007 SHALL use one clock and an asynchronous active-low reset: clk  in  1  system clock; reset_n  in  1  async active-low reset.
REQ-008 SHALL have port i_bin_valid  in  1  bin strobe.
REQ-009 SHALL have port i_bin_addr  in  ADDR_W  bin index.
REQ-010 SHALL have port i_bin_mag  in  MAG_W  bin magnitude.
REQ-011 SHALL have port i_log_mode  in  1  1 = log scale, 0 = linear.
REQ-012 SHALL have port i_swap_req  in  1  single-cycle vblank pulse from the display side.
REQ-013 SHALL have port i_rd_addr  in  ADDR_W  display read address.
REQ-014 SHALL have port o_rd_height  out  H_W  front-buffer height.
REQ-015 SHALL have port o_rd_peak  out  H_W  peak-hold height.
REQ-016 SHALL have port o_frame_valid  out  1  high once a front buffer exists.
REQ-017 SHALL have port o_swap_ack  out  1  single-cycle pulse on swap.
REQ-018 SHALL have port o_drop_cnt  out  16  count of dropped bins, saturating.

Function
REQ-019 SHALL hold two banks of NUM_BINS x H_W (front/back) selected by a bank pointer.
REQ-020 SHALL convert magnitude to height on write:
  - linear: mag >> LIN_SHIFT, saturated to H_MAX;
  - log: 8*msb_index + next 3 bits below the msb, saturated to H_MAX; mag = 0 -> 0.
REQ-021 SHALL run a two-state FSM:
  - FILL: accepted bins are written to back[addr]; acceptance of addr = NUM_BINS-1 -> COMPLETE.
  - COMPLETE: i_swap_req -> toggle pointer, pulse o_swap_ack, set o_frame_valid, -> FILL.
REQ-022 SHALL ignore i_swap_req in FILL; the front buffer is unchanged and no ack is issued.
REQ-023 SHALL drop i_bin_valid in COMPLETE, including a bin coinciding with the swap cycle, and increment o_drop_cnt, saturating at 0xFFFF.
REQ-024 SHALL accept out-of-order or repeated addresses in FILL; the last write wins; only address NUM_BINS-1 completes the frame.
REQ-025 SHALL return o_rd_height with exactly 1-cycle latency from i_rd_addr, reading the front bank selected at the read cycle.
REQ-026 SHALL force o_rd_height to 0 while o_frame_valid is low.
REQ-027 SHALL accept a change of i_log_mode at any time; it affects subsequently written bins only.

Reset
REQ-028 SHALL, with reset_n low, set FILL, bank pointer 0, o_frame_valid 0, o_swap_ack 0, o_drop_cnt 0, o_rd_height 0, o_rd_peak 0.
REQ-029 SHALL NOT reset RAM contents; outputs are masked per REQ-026 and REQ-032.
REQ-030 SHALL abandon a partial frame on reset mid-fill; the next frame restarts in FILL.

Configuration
REQ-031 SHALL include the peak-hold array and its write-side update only when PEAK_HOLD_EN is defined: on each accepted bin, peak[addr] = max(h, peak[addr] - DECAY floored at 0), via a 1-cycle read-modify-write with forwarding for back-to-back same-address writes.
REQ-032 SHALL return o_rd_peak with 1-cycle latency when PEAK_HOLD_EN is defined, forced to 0 until o_frame_valid; without PEAK_HOLD_EN, o_rd_peak SHALL be constant 0 and no peak RAM is inferred.

Structure
REQ-033 SHALL take the FSM state typedef and default widths/H_MAX constants from shared package vga_disp_pkg.
REQ-034 SHALL implement the height conversion of REQ-020 as combinational sub-module mag_to_height.

Verification
REQ-035 Reset, then read addr 0 -> o_rd_height = 0, o_frame_valid = 0.
REQ-036 Linear mode, write bins 0..511 with bin 256 mag 123456, then swap pulse -> o_swap_ack 1 cycle; read 256 -> height 30 one cycle later.
REQ-037 Log mode, mag 500000 (msb 18, next bits 111) -> height 151; mag 0 -> 0; mag 2^23 -> 184; linear mag 0xFFFFFF -> 479.
REQ-038 Swap pulse mid-fill (bin 100) -> no ack, front unchanged; bins sent after a complete frame without a swap -> o_drop_cnt increments per bin.
REQ-039 With PEAK_HOLD_EN, frame 1 bin 5 = 200 then frame 2 bin 5 = 50 -> peak 200 then 198; back-to-back writes to the same address -> correct forwarded max.
REQ-040 Assert reset_n low mid-fill at bin 300 -> state FILL, o_drop_cnt 0, o_frame_valid 0; a subsequent full frame plus swap succeeds.
